// File: rtl/mul_div_sequencer_pkg.sv
// rtl/mul_div_sequencer_pkg.sv - state encoding, opcode constants and opcode helpers for the Mini SRC sequencer
package minisrc_ctrl_pkg;

  localparam int OP_W = 5;

  typedef enum logic [3:0] {
    IDLE,
    T0,
    T1,
    T2,
    T3,
    T4,
    T5,
    T6,
    DONE
  } state_t;

  localparam logic [OP_W-1:0] INC_PC = 5'b11111;
  localparam logic [OP_W-1:0] MUL    = 5'b01111;
  localparam logic [OP_W-1:0] DIV    = 5'b10000;

  // MUL and DIV produce a 64-bit result that is written back through LO then HI.
  function automatic logic is_two_result(input logic [OP_W-1:0] op);
    return (op == MUL) || (op == DIV);
  endfunction

endpackage

// File: rtl/mul_div_sequencer_if.sv
// rtl/mul_div_sequencer_if.sv - sequencer <-> datapath control bundle (master = sequencer, slave = datapath)
interface mul_div_sequencer_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ALU_OP_W = 5
);

  logic                run;
  logic [DATA_W-1:0]   ir;
  logic                mem_ready;

  logic                pc_out;
  logic                pc_en;
  logic                mar_en;
  logic                read;
  logic                mdr_en;
  logic                mdr_out;
  logic                ir_en;
  logic                y_en;
  logic                z_lo_en;
  logic                z_hi_en;
  logic                z_lo_out;
  logic                z_hi_out;
  logic                lo_en;
  logic                hi_en;
  logic [NUM_REGS-1:0] reg_out;
  logic [NUM_REGS-1:0] reg_en;
  logic [ALU_OP_W-1:0] alu_control;
  logic                busy;
  logic                done;
  logic                illegal;

  modport master (
    input  run, ir, mem_ready,
    output pc_out, pc_en, mar_en, read, mdr_en, mdr_out, ir_en, y_en,
           z_lo_en, z_hi_en, z_lo_out, z_hi_out, lo_en, hi_en,
           reg_out, reg_en, alu_control, busy, done, illegal
  );

  modport slave (
    output run, ir, mem_ready,
    input  pc_out, pc_en, mar_en, read, mdr_en, mdr_out, ir_en, y_en,
           z_lo_en, z_hi_en, z_lo_out, z_hi_out, lo_en, hi_en,
           reg_out, reg_en, alu_control, busy, done, illegal
  );

endinterface

// File: rtl/mul_div_sequencer_onehot_dec.sv
// rtl/mul_div_sequencer_onehot_dec.sv - register index to one-hot select, all-zero when not enabled
module onehot_dec #(
  parameter int RSEL_W = 4
) (
  input  logic [RSEL_W-1:0]        idx,
  input  logic                     en,
  output logic [(1<<RSEL_W)-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/mul_div_sequencer.sv
// rtl/mul_div_sequencer.sv - Mini SRC fetch + reg-reg ALU control sequencer with MUL/DIV LO/HI writeback
// Optional memory wait state in T1: MUL_DIV_SEQ_MEM_WAIT_EN
module mul_div_sequencer
  import minisrc_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ALU_OP_W = 5
) (
  input  logic                 clk,
  input  logic                 clr,
  mul_div_sequencer_if.master  bus
);

  localparam int RSEL_W = $clog2(NUM_REGS);

  state_t              state;
  state_t              next_state;
  logic [ALU_OP_W-1:0] opcode;
  logic [ALU_OP_W-1:0] alu_q;
  logic [RSEL_W-1:0]   ra;
  logic [RSEL_W-1:0]   rb;
  logic [RSEL_W-1:0]   rc;
  logic [RSEL_W-1:0]   out_sel;
  logic                out_sel_en;
  logic                wr_sel_en;
  logic                two_result;
  logic                illegal_op;
  logic                illegal_q;
  logic                mem_ack;
  logic                unused_ir_bits;

  assign opcode = bus.ir[DATA_W-1 -: ALU_OP_W];
  assign ra     = bus.ir[DATA_W-ALU_OP_W-1 -: RSEL_W];
  assign rb     = bus.ir[DATA_W-ALU_OP_W-RSEL_W-1 -: RSEL_W];
  assign rc     = bus.ir[DATA_W-ALU_OP_W-2*RSEL_W-1 -: RSEL_W];
  assign unused_ir_bits = ^bus.ir[DATA_W-ALU_OP_W-3*RSEL_W-1:0];

  assign two_result = is_two_result(OP_W'(opcode));
  assign illegal_op = (opcode == ALU_OP_W'(INC_PC));

`ifdef MUL_DIV_SEQ_MEM_WAIT_EN
  assign mem_ack = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign mem_ack          = 1'b1;
  assign unused_mem_ready = bus.mem_ready;
`endif

  // alu_control is loaded on entry to T0/T4 so it is valid for the whole state and holds elsewhere.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      alu_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == T0)      alu_q <= ALU_OP_W'(INC_PC);
      else if (next_state == T4) alu_q <= opcode;
      if (state == T3)           illegal_q <= illegal_op;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.run) next_state = T0;
      T0:      next_state = T1;
      T1:      if (mem_ack) next_state = T2;
      T2:      next_state = T3;
      T3:      next_state = illegal_op ? DONE : T4;
      T4:      next_state = T5;
      T5:      next_state = two_result ? T6 : DONE;
      T6:      next_state = DONE;
      DONE:    next_state = bus.run ? T0 : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.pc_out   = 1'b0;
    bus.pc_en    = 1'b0;
    bus.mar_en   = 1'b0;
    bus.read     = 1'b0;
    bus.mdr_en   = 1'b0;
    bus.mdr_out  = 1'b0;
    bus.ir_en    = 1'b0;
    bus.y_en     = 1'b0;
    bus.z_lo_en  = 1'b0;
    bus.z_hi_en  = 1'b0;
    bus.z_lo_out = 1'b0;
    bus.z_hi_out = 1'b0;
    bus.lo_en    = 1'b0;
    bus.hi_en    = 1'b0;
    bus.done     = 1'b0;
    bus.illegal  = 1'b0;
    case (state)
      T0: begin
        bus.pc_out  = 1'b1;
        bus.mar_en  = 1'b1;
        bus.z_lo_en = 1'b1;
      end
      // PC update and MDR capture only in the T1 exit cycle, however long T1 is held.
      T1: begin
        bus.read     = 1'b1;
        bus.z_lo_out = mem_ack;
        bus.pc_en    = mem_ack;
        bus.mdr_en   = mem_ack;
      end
      T2: begin
        bus.mdr_out = 1'b1;
        bus.ir_en   = 1'b1;
      end
      T3: bus.y_en = 1'b1;
      T4: begin
        bus.z_lo_en = 1'b1;
        bus.z_hi_en = two_result;
      end
      T5: begin
        bus.z_lo_out = 1'b1;
        bus.lo_en    = two_result;
      end
      T6: begin
        bus.z_hi_out = 1'b1;
        bus.hi_en    = 1'b1;
      end
      DONE: begin
        bus.done    = 1'b1;
        bus.illegal = illegal_q;
      end
      default: ;
    endcase
  end

  assign bus.alu_control = alu_q;
  assign bus.busy        = (state != IDLE);

  assign out_sel    = (state == T3) ? rb : rc;
  assign out_sel_en = (state == T3) || (state == T4);
  assign wr_sel_en  = (state == T5) && !two_result;

  onehot_dec #(.RSEL_W(RSEL_W)) u_out_dec (
    .idx    (out_sel),
    .en     (out_sel_en),
    .onehot (bus.reg_out)
  );

  onehot_dec #(.RSEL_W(RSEL_W)) u_en_dec (
    .idx    (ra),
    .en     (wr_sel_en),
    .onehot (bus.reg_en)
  );

endmodule
